// File: rtl/piece_bag_pkg.sv
// Shared tetromino definitions used by the bag, spawn and render logic.
package piece_bag_pkg;

  localparam int PIECE_W    = 3;
  localparam int NUM_PIECES = 7;

  typedef enum logic [PIECE_W-1:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_e;

  localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd7;

  // Lowest-index piece not yet issued from the bag; PIECE_NONE if the bag is exhausted.
  function automatic logic [PIECE_W-1:0] lowest_clear(input logic [NUM_PIECES-1:0] mask);
    lowest_clear = PIECE_NONE;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (!mask[i]) lowest_clear = PIECE_W'(i);
    end
  endfunction

endpackage

// File: rtl/piece_bag_fifo.sv
// Small preview FIFO: registered storage, head and head+1 read combinationally.
module piece_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         second,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr_inc;
  logic             do_push;
  logic             do_pop;

  // Guard both ends so a stray pop on empty or push on full cannot corrupt state.
  assign do_pop     = pop && (count != '0);
  assign do_push    = push && (count < (PW+1)'(DEPTH));
  assign rd_ptr_inc = rd_ptr + PW'(1);
  assign head       = mem[rd_ptr];
  assign second     = mem[rd_ptr_inc];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr_inc;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/piece_bag.sv
// 7-bag piece generator: filters raw random samples into a fair bag sequence
// and queues the result in a preview FIFO for the spawn logic.
module piece_bag
  import piece_bag_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_REJECT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIECE_W-1:0]    random,
  input  logic                  piece_take,
  output logic                  piece_valid,
  output logic [PIECE_W-1:0]    piece_id,
  output logic                  preview_valid,
  output logic [PIECE_W-1:0]    preview_id,
  output logic [NUM_PIECES-1:0] bag_mask,
  output logic                  bag_wrap
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(MAX_REJECT + 1);

  logic [CW-1:0]         count;
  logic [PIECE_W-1:0]    head;
  logic [PIECE_W-1:0]    second;
  logic [RW-1:0]         reject_cnt;
  logic [NUM_PIECES:0]   taken_ext;
  logic                  bag_done;
  logic                  fill_en;
  logic                  accept;
  logic                  fallback;
  logic                  push;
  logic [PIECE_W-1:0]    push_id;

  // The extra top bit makes PIECE_NONE look permanently taken, so 7 is always rejected.
  assign taken_ext = {1'b1, bag_mask};
  assign bag_done  = (bag_mask == {NUM_PIECES{1'b1}});
  assign fill_en   = (count < CW'(DEPTH)) && !bag_done;
  assign accept    = !taken_ext[random];
  assign fallback  = (reject_cnt == RW'(MAX_REJECT));
  assign push      = fill_en && (fallback || accept);
  assign push_id   = fallback ? lowest_clear(bag_mask) : random;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bag_mask   <= '0;
      bag_wrap   <= 1'b0;
      reject_cnt <= '0;
    end else begin
      bag_wrap <= bag_done;
      if (bag_done)  bag_mask <= '0;
      else if (push) bag_mask <= bag_mask | (NUM_PIECES'(1) << push_id);
      if (fill_en)   reject_cnt <= push ? '0 : reject_cnt + 1'b1;
    end
  end

  piece_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIECE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_id),
    .pop       (piece_take),
    .head      (head),
    .second    (second),
    .count     (count)
  );

  assign piece_valid   = (count != '0);
  assign preview_valid = (count >= CW'(2));
  assign piece_id      = piece_valid ? head : '0;
  assign preview_id    = preview_valid ? second : '0;

endmodule
